dynamic_clock_governor: RTL and testbench
=========================================

Name: dynamic_clock_governor

Overview:
Controller that sequences frequency changes for the integer-divider dynamic clock.
- Arbitrates divide-ratio requests from N_REQ requesters (accelerator FSMs, performance monitors) round-robin.
- Drives the divider's valid / frequency_setting_request pair, then enforces a settle window and a minimum dwell time before accepting the next change.
- Sits beside the divider in the clk_fast domain and is the only agent allowed to drive its setting inputs.

Parameters:
M, 4, width of a divide-ratio setting
N_REQ, 4, number of requesters (1..8)
INIT, 2, setting after reset; must equal the divider's init value; legal range 2..2^M-1
MIN_DWELL, 8, minimum clk_fast cycles spent in DWELL after each applied change (1..65535)

Ports:
clk_fast  input  1  fast source clock; all logic on its rising edge
reset_n  input  1  synchronous active-low reset
req_valid  input  N_REQ  per-requester request strobe; held until granted
req_setting  input  N_REQ*M  requested ratio; requester i owns bits [i*M +: M]
req_ready  output  N_REQ  one-hot, one-cycle grant/ack to the accepted requester
valid  output  1  one-cycle load strobe to the divider
frequency_setting_request  output  M  ratio presented to the divider
current_setting  output  M  last ratio applied (or INIT)
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock is clk_fast. Reset is synchronous, active-low (reset_n), sampled on the rising edge of clk_fast.
- Reset values:
  - valid=0, req_ready=0, busy=0.
  - frequency_setting_request=INIT, current_setting=INIT.
  - Round-robin pointer=0, state=IDLE, counters=0.
  - Reset asserted in any state aborts the sequence immediately; no valid pulse is produced on the reset cycle.
- All outputs are registered.
- FSM states: IDLE, ISSUE, SETTLE, DWELL.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - On the grant cycle: req_ready[g]=1 at the next edge, and the pointer becomes (g+1) mod N_REQ.
  - Clamp: a granted setting below 2 is replaced by 2. Ratios 0 and 1 are illegal for the divider.
  - If the clamped setting equals current_setting, the request is acked only: no valid pulse, and the FSM stays in IDLE.
  - Otherwise, latch the clamped value into frequency_setting_request and new_r, then go to ISSUE.
  - With no requests, the FSM stays in IDLE and all strobes are low.
- ISSUE (1 cycle):
  - valid=1 for exactly this one cycle.
  - current_setting updates to new_r at the end of the cycle.
  - Load the settle counter with old_setting + new_r − 1. This is M+1 bits wide and cannot overflow.
  - Go to SETTLE.
- SETTLE:
  - Decrement each cycle; at 0 go to DWELL and load the dwell counter (16 bits) with MIN_DWELL − 1.
  - This covers completion of the old divided period plus one full new period.
- DWELL: decrement each cycle; at 0 go to IDLE.
- While busy:
  - Requests are not granted and req_ready stays 0.
  - Requesters keep req_valid asserted, and pending requests are not lost.
- frequency_setting_request holds its value between changes. It changes only on the grant cycle that leads to ISSUE.
- req_ready is never asserted to more than one requester per cycle. It is never asserted in a cycle where req_valid for that requester was low on the previous edge.
- Total latency from an accepted change to next grant possible: 1 (grant) + 1 (ISSUE) + (old+new) + MIN_DWELL cycles.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req_valid=4'b1111 -> valid=0, req_ready=0, frequency_setting_request=2, current_setting=2, busy=0. First grant after release goes to requester 0.
- Single change: req 1 asks 6 from IDLE (current=2).
  - Next cycle: req_ready=4'b0010.
  - Following cycle: valid=1, frequency_setting_request=6.
  - busy stays high for 1+7+8 cycles after the ISSUE cycle.
  - current_setting becomes 6.
- Round-robin: all four requesters hold distinct settings 3, 4, 5, 7 -> grants in order 0, 1, 2, 3, then 0 again. Each grant is separated by the full ISSUE+SETTLE+DWELL sequence, and each produces exactly one valid pulse.
- Redundant request: current=5, req 2 asks 5 -> req_ready=4'b0100 for 1 cycle, no valid pulse, busy stays 0.
- Clamp: req 3 asks 0, then later asks 1 -> valid pulses with frequency_setting_request=2 (the second request is acked only if current is already 2).
- Reset mid-SETTLE: assert reset_n=0 during SETTLE -> next edge state=IDLE, busy=0, settings back to INIT, no further valid pulse.

Source files
------------

// File: rtl/dynamic_clock_governor_if.sv
// Request/grant and divider-load bundle between the requesters, the governor and the divider.
// Handshake: a requester raises req_valid[i] with req_setting[i*M +: M] and holds both until the
// governor answers with a one-cycle req_ready[i]; valid is a one-cycle load strobe with no back-pressure.
interface dynamic_clock_governor_if #(
    parameter int M     = 4,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*M-1:0] req_setting;
    logic [N_REQ-1:0]   req_ready;
    logic               valid;
    logic [M-1:0]       frequency_setting_request;
    logic [M-1:0]       current_setting;
    logic               busy;

    modport master (
        output req_valid, req_setting,
        input  req_ready, valid, frequency_setting_request, current_setting, busy
    );

    modport slave (
        input  req_valid, req_setting,
        output req_ready, valid, frequency_setting_request, current_setting, busy
    );
endinterface

// File: rtl/dynamic_clock_governor.sv
// Sequences divide-ratio changes for the integer-divider clock: round-robin grant, one load
// strobe, then a settle window (old+new cycles) and a minimum dwell before the next change.
module dynamic_clock_governor #(
    parameter int M         = 4,
    parameter int N_REQ     = 4,
    parameter int INIT      = 2,
    parameter int MIN_DWELL = 8
) (
    input  logic                   clk_fast,
    input  logic                   reset_n,
    dynamic_clock_governor_if.slave bus,
    output logic [1:0]             state_dbg
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DWELL} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [M-1:0]     new_r, new_n;
    logic [M:0]       settle_cnt, settle_n;
    logic [15:0]      dwell_cnt, dwell_n;
    logic [N_REQ-1:0] ready_r, ready_n;
    logic             valid_r, valid_n;
    logic [M-1:0]     fsr_r, fsr_n;
    logic [M-1:0]     cur_r, cur_n;
    logic             busy_r;

    logic             found;
    int               gidx;
    int               idx;
    logic [M-1:0]     sel;
    logic [M-1:0]     clamped;

    always_ff @(posedge clk_fast) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            new_r      <= M'(INIT);
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            ready_r    <= '0;
            valid_r    <= 1'b0;
            fsr_r      <= M'(INIT);
            cur_r      <= M'(INIT);
            busy_r     <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            new_r      <= new_n;
            settle_cnt <= settle_n;
            dwell_cnt  <= dwell_n;
            ready_r    <= ready_n;
            valid_r    <= valid_n;
            fsr_r      <= fsr_n;
            cur_r      <= cur_n;
            busy_r     <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        new_n    = new_r;
        settle_n = settle_cnt;
        dwell_n  = dwell_cnt;
        ready_n  = '0;
        valid_n  = 1'b0;
        fsr_n    = fsr_r;
        cur_n    = cur_r;
        found    = 1'b0;
        gidx     = 0;
        idx      = 0;

        // First pending requester at or after the pointer, wrapping.
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        sel     = bus.req_setting[gidx*M +: M];
        clamped = (sel < M'(2)) ? M'(2) : sel;

        case (state)
            IDLE: begin
                if (found) begin
                    ready_n[gidx] = 1'b1;
                    ptr_n         = PW'((gidx + 1) % N_REQ);
                    if (clamped != cur_r) begin
                        fsr_n   = clamped;
                        new_n   = clamped;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                valid_n  = 1'b1;
                cur_n    = new_r;
                // Finish the old divided period, then one full new period.
                settle_n = {1'b0, cur_r} + {1'b0, new_r} - (M+1)'(1);
                state_n  = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    dwell_n = 16'(MIN_DWELL - 1);
                    state_n = DWELL;
                end else begin
                    settle_n = settle_cnt - (M+1)'(1);
                end
            end
            DWELL: begin
                if (dwell_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    dwell_n = dwell_cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready                 = ready_r;
    assign bus.valid                     = valid_r;
    assign bus.frequency_setting_request = fsr_r;
    assign bus.current_setting           = cur_r;
    assign bus.busy                      = busy_r;
    assign state_dbg                     = state;
endmodule

// File: tb/tb_dynamic_clock_governor.sv
// Directed bench for dynamic_clock_governor: reset, round-robin changes, single change,
// redundant ack, clamping and reset during SETTLE, with hand-derived cycle timing.
module tb_dynamic_clock_governor;
    localparam int M         = 4;
    localparam int N_REQ     = 4;
    localparam int MIN_DWELL = 8;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DWELL  = 2'd3;

    logic       clk_fast;
    logic       reset_n;
    logic [1:0] state_dbg;
    int         vectors;
    int         miscompares;

    dynamic_clock_governor_if #(.M(M), .N_REQ(N_REQ)) bus ();

    dynamic_clock_governor #(.M(M), .N_REQ(N_REQ), .INIT(2), .MIN_DWELL(MIN_DWELL)) dut (
        .clk_fast  (clk_fast),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int idx, input logic [3:0] val);
        bus.req_setting[idx*M +: M] = val;
        bus.req_valid[idx]          = 1'b1;
    endtask

    // Grant cycle, ISSUE cycle, then old+new SETTLE cycles and MIN_DWELL DWELL cycles.
    task automatic run_change(input int idx, input int old_s, input int new_s);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << idx;
        tick();
        check("grant_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("grant_fsr",   32'(bus.frequency_setting_request), 32'(new_s));
        check("grant_cur",   32'(bus.current_setting), 32'(old_s));
        check("grant_valid", 32'(bus.valid), 32'd0);
        check("grant_busy",  32'(bus.busy), 32'd1);
        check("grant_state", 32'(state_dbg), 32'(S_ISSUE));
        bus.req_valid[idx] = 1'b0;
        tick();
        check("issue_valid", 32'(bus.valid), 32'd1);
        check("issue_cur",   32'(bus.current_setting), 32'(new_s));
        check("issue_ready", 32'(bus.req_ready), 32'd0);
        check("issue_state", 32'(state_dbg), 32'(S_SETTLE));
        for (int i = 1; i <= old_s + new_s - 1 + MIN_DWELL; i++) begin
            tick();
            check("wait_busy",  32'({bus.busy, bus.valid, bus.req_ready}), 32'b1_0_0000);
            check("wait_state", 32'(state_dbg),
                  (i <= old_s + new_s - 1) ? 32'(S_SETTLE) : 32'(S_DWELL));
        end
        tick();
        check("done_busy",  32'(bus.busy), 32'd0);
        check("done_state", 32'(state_dbg), 32'(S_IDLE));
        check("done_fsr",   32'(bus.frequency_setting_request), 32'(new_s));
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset_n         = 1'b0;
        bus.req_valid   = 4'b1111;
        bus.req_setting = {4'd7, 4'd5, 4'd4, 4'd3};

        // Reset held with all requests pending.
        repeat (3) tick();
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_fsr",   32'(bus.frequency_setting_request), 32'd2);
        check("rst_cur",   32'(bus.current_setting), 32'd2);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset_n = 1'b1;

        // Round-robin across four held requests, then requester 0 again.
        run_change(0, 2, 3);
        run_change(1, 3, 4);
        run_change(2, 4, 5);
        run_change(3, 5, 7);
        post(0, 4'd2);
        run_change(0, 7, 2);

        // Single change from 2 to 6.
        post(1, 4'd6);
        run_change(1, 2, 6);

        // Move to 5, then a redundant request for 5 is only acknowledged.
        post(2, 4'd5);
        run_change(2, 6, 5);
        post(2, 4'd5);
        tick();
        check("redund_ready", 32'(bus.req_ready), 32'b0100);
        check("redund_valid", 32'(bus.valid), 32'd0);
        check("redund_busy",  32'(bus.busy), 32'd0);
        check("redund_state", 32'(state_dbg), 32'(S_IDLE));
        bus.req_valid[2] = 1'b0;
        tick();
        check("redund_ready2", 32'(bus.req_ready), 32'd0);
        check("redund_valid2", 32'(bus.valid), 32'd0);
        check("redund_cur",    32'(bus.current_setting), 32'd5);

        // Clamp: 0 becomes 2; a later 1 also becomes 2 and is ack-only.
        post(3, 4'd0);
        run_change(3, 5, 2);
        post(3, 4'd1);
        tick();
        check("clamp1_ready", 32'(bus.req_ready), 32'b1000);
        check("clamp1_valid", 32'(bus.valid), 32'd0);
        check("clamp1_busy",  32'(bus.busy), 32'd0);
        bus.req_valid[3] = 1'b0;
        tick();
        check("clamp1_valid2", 32'(bus.valid), 32'd0);
        check("clamp1_fsr",    32'(bus.frequency_setting_request), 32'd2);

        // Reset during SETTLE aborts the change.
        post(1, 4'd9);
        tick();
        check("abort_ready", 32'(bus.req_ready), 32'b0010);
        bus.req_valid[1] = 1'b0;
        tick();
        check("abort_valid", 32'(bus.valid), 32'd1);
        check("abort_cur",   32'(bus.current_setting), 32'd9);
        tick();
        tick();
        check("abort_pre_state", 32'(state_dbg), 32'(S_SETTLE));
        reset_n = 1'b0;
        tick();
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_cur2",  32'(bus.current_setting), 32'd2);
        check("abort_fsr",   32'(bus.frequency_setting_request), 32'd2);
        check("abort_valid2", 32'(bus.valid), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_abort", 32'({bus.busy, bus.valid, bus.req_ready}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
